scaler_stream_framer: RTL and testbench
=======================================

Name: scaler_stream_framer

Overview:
- Receive side of the scaler output stream. Takes the unframed gray pixel stream from scaler_gray_top (tvalid_o/tdata_o, which has no backpressure).
- Buffers pixels in a FIFO and re-emits them as a framed stream with start-of-frame (tuser) and end-of-line (tlast) markers, under downstream tready.
- Sits between the scaler and the frame writer or display path. Detects lost pixels and frame completion.

Parameters:
- DATA_WIDTH, 8, pixel width.
- DIM_WIDTH, 16, width of the dimension inputs and the column/row counters.
- FIFO_DEPTH, 64, buffer entries; power of two, at least 4.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- tvalid_i  in  1  scaler pixel valid; no ready is returned upstream.
- tdata_i  in  DATA_WIDTH  scaler pixel.
- dest_width_i  in  DIM_WIDTH  output line length in pixels; must be at least 1.
- dest_height_i  in  DIM_WIDTH  output frame height in lines; must be at least 1.
- m_tvalid_o  out  1  framed pixel valid.
- m_tdata_o  out  DATA_WIDTH  framed pixel.
- m_tuser_o  out  1  first pixel of frame.
- m_tlast_o  out  1  last pixel of line.
- m_tready_i  in  1  downstream ready.
- ovf_clr_i  in  1  clears overflow_o.
- overflow_o  out  1  sticky; a pixel was dropped.
- frame_done_o  out  1  one-cycle pulse when a frame has fully drained.
- fill_o  out  log2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async assert, released synchronously to clk_i): m_tvalid_o=0, m_tdata_o=0, m_tuser_o=0, m_tlast_o=0, overflow_o=0, frame_done_o=0, fill_o=0. Counters are 0, FIFO is empty, state is S_IDLE.
- An input pixel is accepted on any cycle with tvalid_i=1.
- Tag generation at write time:
  - col counts 0..W-1; row counts 0..H-1.
  - tuser = (col==0 && row==0).
  - tlast = (col==W-1).
  - Both tags are stored in the FIFO with the pixel.
- W and H are latched from dest_width_i/dest_height_i on the first pixel accepted in S_IDLE. Dimension changes mid-frame are ignored until the next frame.
- State machine:
  - S_IDLE: on tvalid_i, latch W and H, write the pixel, go to S_ACTIVE. If W==1 and H==1, go straight to S_DRAIN.
  - S_ACTIVE: every tvalid_i advances col; at col==W-1, col wraps to 0 and row increments. The pixel with col==W-1 and row==H-1 moves the state to S_DRAIN.
  - S_DRAIN: further tvalid_i pixels are dropped, overflow_o is set, and counters hold. When the frame's final pixel (tlast, last row) completes the m_tvalid_o&&m_tready_i handshake, frame_done_o pulses for 1 cycle and the state returns to S_IDLE.
- FIFO is show-ahead: m_tvalid_o = !empty, and m_tdata_o/m_tuser_o/m_tlast_o reflect the head entry.
  - Latency: a pixel written at edge N is visible on the outputs after edge N, i.e. usable at edge N+1, when the FIFO was empty.
  - Head pops on m_tvalid_o&&m_tready_i.
  - m_tvalid_o never drops while waiting on m_tready_i, and the head entry stays stable during a stall.
- Full handling:
  - FIFO full with tvalid_i and no pop in the same cycle: the pixel is dropped and overflow_o is set. Col/row still advance so framing stays aligned.
  - FIFO full with tvalid_i and a pop in the same cycle: write accepted, fill unchanged.
  - FIFO empty with a write: no pop that cycle; the new entry is valid the next cycle.
- overflow_o is sticky until ovf_clr_i. If ovf_clr_i and a new drop occur in the same cycle, the set wins.
- Pointers wrap modulo FIFO_DEPTH. fill_o = writes - pops, range 0..FIFO_DEPTH.
- Reset mid-frame: FIFO contents are discarded, the state returns to S_IDLE, and the next pixel is treated as a frame start.

Test Plan:
- W=4, H=2, m_tready_i=1, 8 pixels 0x10..0x17 back-to-back.
  - Output 0x10..0x17 in order, each one cycle after input.
  - tuser only on 0x10; tlast on 0x13 and 0x17.
  - frame_done_o pulses one cycle after 0x17 is handshaken; overflow_o=0.
- W=4, H=2, m_tready_i=0 for 5 cycles during input, then 1.
  - All 8 pixels out in order with no loss; fill_o peaks at 5.
  - m_tdata_o is held stable while stalled.
- FIFO_DEPTH=4, m_tready_i=0, 6 pixels in.
  - fill_o=4; pixels 5 and 6 dropped; overflow_o=1.
  - Pixel 6's counter position is still consumed; after ovf_clr_i, overflow_o=0.
- FIFO full with m_tready_i=1 and tvalid_i in the same cycle: pixel accepted, fill_o stays 4, overflow_o stays 0.
- W=1, H=1, single pixel 0xAB: m_tuser_o=1 and m_tlast_o=1 on that beat; frame_done_o pulses; a following pixel starts a new frame with tuser=1.
- Assert rst_i after 3 of 8 pixels: outputs go to 0 immediately; the next pixel appears with tuser=1 and the new W/H are latched.

Source files
------------

// File: rtl/scaler_stream_framer.sv
// Frames the unframed scaler pixel stream with SOF (tuser) and EOL (tlast) tags via a show-ahead FIFO.
// Latency: 1 cycle from tvalid_i to m_tvalid_o when empty; backpressure: m_tready_i stalls the FIFO, overflowing pixels are dropped.
module scaler_stream_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM_WIDTH  = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              tvalid_i,
  input  logic [DATA_WIDTH-1:0]             tdata_i,
  input  logic [DIM_WIDTH-1:0]              dest_width_i,
  input  logic [DIM_WIDTH-1:0]              dest_height_i,
  output logic                              m_tvalid_o,
  output logic [DATA_WIDTH-1:0]             m_tdata_o,
  output logic                              m_tuser_o,
  output logic                              m_tlast_o,
  input  logic                              m_tready_i,
  input  logic                              ovf_clr_i,
  output logic                              overflow_o,
  output logic                              frame_done_o,
  output logic [$clog2(FIFO_DEPTH):0]       fill_o
);

  localparam int ENTRY_W = DATA_WIDTH + 3;
  localparam logic [DIM_WIDTH-1:0] DIM_ONE = DIM_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DIM_WIDTH-1:0] w_q, w_d, h_q, h_d;
  logic [DIM_WIDTH-1:0] col_q, col_d, row_q, row_d;
  logic [DIM_WIDTH-1:0] w_eff, h_eff;
  logic                 ovf_q, ovf_d;
  logic                 frame_done_q, frame_done_d;
  logic                 eof_lost_q, eof_lost_d;

  logic                 accept, latch_dims;
  logic                 col_last, row_last, frame_end;
  logic                 full, pop, wr_en, drop, drain_done;
  logic                 head_vld, head_eof, head_tuser, head_tlast;
  logic [DATA_WIDTH-1:0] head_data;
  logic [ENTRY_W-1:0]   wr_entry, head_entry;

  // In S_IDLE the incoming pixel already uses the dimensions being latched.
  assign w_eff     = (state_q == S_IDLE) ? dest_width_i  : w_q;
  assign h_eff     = (state_q == S_IDLE) ? dest_height_i : h_q;
  assign col_last  = (col_q == w_eff - DIM_ONE);
  assign row_last  = (row_q == h_eff - DIM_ONE);
  assign frame_end = col_last && row_last;

  assign pop   = head_vld && m_tready_i;
  assign wr_en = accept && (!full || pop);
  assign drop  = tvalid_i && !wr_en;

  // eof marks the frame's final pixel so the read side knows when the frame has drained.
  assign wr_entry = {frame_end, (col_q == '0) && (row_q == '0), col_last, tdata_i};
  assign {head_eof, head_tuser, head_tlast, head_data} = head_entry;

  // A dropped final pixel would never be handshaken; finish the frame once the FIFO empties instead.
  assign drain_done = (pop && head_eof) || (eof_lost_q && !head_vld);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (tvalid_i) begin
          state_d = frame_end ? S_DRAIN : S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (tvalid_i && frame_end) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    accept     = 1'b0;
    latch_dims = 1'b0;
    case (state_q)
      S_IDLE: begin
        accept     = tvalid_i;
        latch_dims = tvalid_i;
      end
      S_ACTIVE: accept = tvalid_i;
      default: accept = 1'b0;
    endcase
  end

  always_comb begin
    w_d          = w_q;
    h_d          = h_q;
    col_d        = col_q;
    row_d        = row_q;
    eof_lost_d   = eof_lost_q;
    frame_done_d = (state_q == S_DRAIN) && drain_done;
    ovf_d        = ovf_q;

    if (latch_dims) begin
      w_d = dest_width_i;
      h_d = dest_height_i;
    end

    // Counters advance even for dropped pixels so framing stays aligned.
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + DIM_ONE;
      end else begin
        col_d = col_q + DIM_ONE;
      end
      if (frame_end && !wr_en) begin
        eof_lost_d = 1'b1;
      end
    end

    if ((state_q == S_DRAIN) && drain_done) begin
      eof_lost_d = 1'b0;
    end

    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_q          <= '0;
      h_q          <= '0;
      col_q        <= '0;
      row_q        <= '0;
      eof_lost_q   <= 1'b0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      w_q          <= w_d;
      h_q          <= h_d;
      col_q        <= col_d;
      row_q        <= row_d;
      eof_lost_q   <= eof_lost_d;
      frame_done_q <= frame_done_d;
      ovf_q        <= ovf_d;
    end
  end

  ssf_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_vld_i (wr_en),
    .wr_dat_i (wr_entry),
    .rd_rdy_i (pop),
    .rd_vld_o (head_vld),
    .rd_dat_o (head_entry),
    .full_o   (full),
    .fill_o   (fill_o)
  );

  assign m_tvalid_o   = head_vld;
  assign m_tdata_o    = head_data;
  assign m_tuser_o    = head_tuser;
  assign m_tlast_o    = head_tlast;
  assign overflow_o   = ovf_q;
  assign frame_done_o = frame_done_q;

endmodule

// Generic show-ahead FIFO; head data reads as zero while empty.
// Latency: a write is visible at the head the cycle after it lands; backpressure: full accepts a write only alongside a read.
module ssf_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_vld_i,
  input  logic [WIDTH-1:0]         wr_dat_i,
  input  logic                     rd_rdy_i,
  output logic                     rd_vld_o,
  output logic [WIDTH-1:0]         rd_dat_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   fill_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             empty, push, pull;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full_o = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pull   = rd_rdy_i && !empty;
  assign push   = wr_vld_i && (!full_o || pull);

  assign wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
  assign rd_ptr_d = pull ? rd_ptr_q + PTR_ONE : rd_ptr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
    end
  end

  assign rd_vld_o = !empty;
  assign rd_dat_o = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign fill_o   = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_scaler_stream_framer.sv
// Directed bench: a 64-deep instance for framing/stall/reset, a 4-deep instance for overflow.
module tb_scaler_stream_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       a_tvalid = 1'b0, a_rdy = 1'b0, a_clr = 1'b0;
  logic [7:0] a_tdata = '0;
  logic [15:0] a_w = 16'd4, a_h = 16'd2;
  logic       a_mv, a_mu, a_ml, a_ovf, a_fd;
  logic [7:0] a_md;
  logic [6:0] a_fill;

  logic       b_tvalid = 1'b0, b_rdy = 1'b0, b_clr = 1'b0;
  logic [7:0] b_tdata = '0;
  logic [15:0] b_w = 16'd4, b_h = 16'd2;
  logic       b_mv, b_mu, b_ml, b_ovf, b_fd;
  logic [7:0] b_md;
  logic [2:0] b_fill;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scaler_stream_framer dut_a (
    .clk_i(clk), .rst_i(rst), .tvalid_i(a_tvalid), .tdata_i(a_tdata),
    .dest_width_i(a_w), .dest_height_i(a_h),
    .m_tvalid_o(a_mv), .m_tdata_o(a_md), .m_tuser_o(a_mu), .m_tlast_o(a_ml),
    .m_tready_i(a_rdy), .ovf_clr_i(a_clr), .overflow_o(a_ovf),
    .frame_done_o(a_fd), .fill_o(a_fill)
  );

  scaler_stream_framer #(.FIFO_DEPTH(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .tvalid_i(b_tvalid), .tdata_i(b_tdata),
    .dest_width_i(b_w), .dest_height_i(b_h),
    .m_tvalid_o(b_mv), .m_tdata_o(b_md), .m_tuser_o(b_mu), .m_tlast_o(b_ml),
    .m_tready_i(b_rdy), .ovf_clr_i(b_clr), .overflow_o(b_ovf),
    .frame_done_o(b_fd), .fill_o(b_fill)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_mv, a_md, a_mu, a_ml, a_ovf, a_fd, a_fill} !== 20'd0) begin
      errors++;
      $display("FAIL reset_a got %0h exp 0", {a_mv, a_md, a_mu, a_ml, a_ovf, a_fd, a_fill});
    end
    checks++;
    if ({b_mv, b_md, b_mu, b_ml, b_ovf, b_fd, b_fill} !== 16'd0) begin
      errors++;
      $display("FAIL reset_b got %0h exp 0", {b_mv, b_md, b_mu, b_ml, b_ovf, b_fd, b_fill});
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    a_w = 16'd4; a_h = 16'd2; a_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_tvalid = 1'b1;
      a_tdata  = 8'h10 + 8'(i);
      if (i == 0) begin
        checks++;
        if (a_mv !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0d exp 0", a_mv); end
      end else begin
        checks++;
        if ({a_mv, a_md} !== {1'b1, 8'h10 + 8'(i - 1)}) begin
          errors++; $display("FAIL b2b_data got %0h exp %0h", {a_mv, a_md}, {1'b1, 8'h10 + 8'(i - 1)});
        end
        checks++;
        if ({a_mu, a_ml} !== {(i == 1), (i == 4)}) begin
          errors++; $display("FAIL b2b_tags got %0b exp %0b", {a_mu, a_ml}, {(i == 1), (i == 4)});
        end
        checks++;
        if (a_fill !== 7'd1) begin errors++; $display("FAIL b2b_fill got %0d exp 1", a_fill); end
      end
      tick();
    end
    a_tvalid = 1'b0;
    checks++;
    if ({a_mv, a_md, a_mu, a_ml, a_fd} !== {1'b1, 8'h17, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL b2b_last got %0h exp %0h", {a_mv, a_md, a_mu, a_ml, a_fd}, {1'b1, 8'h17, 1'b0, 1'b1, 1'b0});
    end
    tick();
    checks++;
    if ({a_fd, a_mv, a_ovf} !== 3'b100) begin
      errors++; $display("FAIL b2b_done got %0b exp 100", {a_fd, a_mv, a_ovf});
    end
    tick();
    checks++;
    if (a_fd !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse got %0d exp 0", a_fd); end
  endtask

  task automatic test_stall();
    int idx = 0;
    int max_fill = 0;
    int dones = 0;
    a_w = 16'd4; a_h = 16'd2;
    for (int cyc = 0; cyc < 30; cyc++) begin
      a_tvalid = (cyc < 8);
      a_tdata  = 8'h20 + 8'(cyc);
      a_rdy    = (cyc >= 5);
      if (int'(a_fill) > max_fill) max_fill = int'(a_fill);
      if (a_fd) dones++;
      if (cyc >= 1 && cyc <= 4) begin
        checks++;
        if ({a_mv, a_md} !== {1'b1, 8'h20}) begin
          errors++; $display("FAIL stall_hold got %0h exp %0h", {a_mv, a_md}, {1'b1, 8'h20});
        end
      end
      if (a_mv && a_rdy) begin
        checks++;
        if ({a_md, a_mu, a_ml} !== {8'h20 + 8'(idx), (idx == 0), (idx == 3 || idx == 7)}) begin
          errors++; $display("FAIL stall_out got %0h exp %0h", {a_md, a_mu, a_ml},
                             {8'h20 + 8'(idx), (idx == 0), (idx == 3 || idx == 7)});
        end
        idx++;
      end
      tick();
    end
    checks++;
    if (idx != 8) begin errors++; $display("FAIL stall_count got %0d exp 8", idx); end
    checks++;
    if (max_fill != 5) begin errors++; $display("FAIL stall_peak got %0d exp 5", max_fill); end
    checks++;
    if (dones != 1 || a_ovf !== 1'b0) begin
      errors++; $display("FAIL stall_done got %0d/%0d exp 1/0", dones, a_ovf);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_d [6];
    logic       exp_l [6];
    int idx = 0;
    int dones = 0;
    exp_d[0] = 8'h30; exp_d[1] = 8'h31; exp_d[2] = 8'h32;
    exp_d[3] = 8'h33; exp_d[4] = 8'h36; exp_d[5] = 8'h37;
    exp_l[0] = 1'b0; exp_l[1] = 1'b0; exp_l[2] = 1'b0;
    exp_l[3] = 1'b1; exp_l[4] = 1'b0; exp_l[5] = 1'b1;
    b_w = 16'd4; b_h = 16'd2; b_rdy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      b_tvalid = 1'b1;
      b_tdata  = 8'h30 + 8'(c);
      b_clr    = (c == 5);
      checks++;
      if (b_fill !== 3'((c < 4) ? c : 4)) begin
        errors++; $display("FAIL ovf_fill got %0d exp %0d", b_fill, (c < 4) ? c : 4);
      end
      if (c >= 4) begin
        checks++;
        if (b_ovf !== (c == 5)) begin errors++; $display("FAIL ovf_flag got %0d exp %0d", b_ovf, (c == 5)); end
      end
      tick();
    end
    b_tvalid = 1'b0;
    b_clr    = 1'b0;
    checks++;
    if ({b_fill, b_ovf, b_md, b_mu} !== {3'd4, 1'b1, 8'h30, 1'b1}) begin
      errors++; $display("FAIL ovf_full got %0h exp %0h", {b_fill, b_ovf, b_md, b_mu}, {3'd4, 1'b1, 8'h30, 1'b1});
    end
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    checks++;
    if (b_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0d exp 0", b_ovf); end
    for (int cyc = 0; cyc < 20; cyc++) begin
      b_rdy    = 1'b1;
      b_tvalid = (cyc == 4 || cyc == 5);
      b_tdata  = 8'h36 + 8'(cyc - 4);
      if (b_fd) dones++;
      if (b_mv && b_rdy && idx < 6) begin
        checks++;
        if ({b_md, b_ml} !== {exp_d[idx], exp_l[idx]}) begin
          errors++; $display("FAIL ovf_out got %0h exp %0h", {b_md, b_ml}, {exp_d[idx], exp_l[idx]});
        end
        idx++;
      end
      tick();
    end
    b_tvalid = 1'b0;
    checks++;
    if (idx != 6 || dones != 1 || b_ovf !== 1'b0 || b_mv !== 1'b0) begin
      errors++; $display("FAIL ovf_end got %0d/%0d/%0d/%0d exp 6/1/0/0", idx, dones, b_ovf, b_mv);
    end
  endtask

  task automatic test_full_pop();
    int idx = 1;
    int dones = 0;
    b_w = 16'd4; b_h = 16'd2; b_rdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      b_tvalid = 1'b1;
      b_tdata  = 8'h40 + 8'(c);
      tick();
    end
    b_rdy   = 1'b1;
    b_tdata = 8'h44;
    checks++;
    if (b_fill !== 3'd4) begin errors++; $display("FAIL fullpop_pre got %0d exp 4", b_fill); end
    tick();
    checks++;
    if ({b_fill, b_ovf, b_md, b_mu} !== {3'd4, 1'b0, 8'h41, 1'b0}) begin
      errors++; $display("FAIL fullpop_post got %0h exp %0h", {b_fill, b_ovf, b_md, b_mu}, {3'd4, 1'b0, 8'h41, 1'b0});
    end
    for (int cyc = 0; cyc < 20; cyc++) begin
      b_tvalid = (cyc < 3);
      b_tdata  = 8'h45 + 8'(cyc);
      if (b_fd) dones++;
      if (b_mv && b_rdy) begin
        checks++;
        if ({b_md, b_ml} !== {8'h40 + 8'(idx), (idx == 3 || idx == 7)}) begin
          errors++; $display("FAIL fullpop_out got %0h exp %0h", {b_md, b_ml}, {8'h40 + 8'(idx), (idx == 3 || idx == 7)});
        end
        idx++;
      end
      tick();
    end
    checks++;
    if (idx != 8 || dones != 1 || b_ovf !== 1'b0) begin
      errors++; $display("FAIL fullpop_end got %0d/%0d/%0d exp 8/1/0", idx, dones, b_ovf);
    end
  endtask

  task automatic test_single_pixel();
    a_w = 16'd1; a_h = 16'd1; a_rdy = 1'b1;
    a_tvalid = 1'b1; a_tdata = 8'hAB;
    tick();
    a_tdata = 8'hEE; a_rdy = 1'b0;
    checks++;
    if ({a_mv, a_md, a_mu, a_ml} !== {1'b1, 8'hAB, 2'b11}) begin
      errors++; $display("FAIL single_beat got %0h exp %0h", {a_mv, a_md, a_mu, a_ml}, {1'b1, 8'hAB, 2'b11});
    end
    tick();
    a_tvalid = 1'b0; a_rdy = 1'b1;
    checks++;
    if ({a_ovf, a_fill, a_md} !== {1'b1, 7'd1, 8'hAB}) begin
      errors++; $display("FAIL single_drain_drop got %0h exp %0h", {a_ovf, a_fill, a_md}, {1'b1, 7'd1, 8'hAB});
    end
    tick();
    checks++;
    if ({a_fd, a_mv} !== 2'b10) begin errors++; $display("FAIL single_done got %0b exp 10", {a_fd, a_mv}); end
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    a_tvalid = 1'b1; a_tdata = 8'hCD;
    tick();
    a_tvalid = 1'b0;
    checks++;
    if ({a_ovf, a_mv, a_md, a_mu, a_ml} !== {2'b01, 8'hCD, 2'b11}) begin
      errors++; $display("FAIL single_next got %0h exp %0h", {a_ovf, a_mv, a_md, a_mu, a_ml}, {2'b01, 8'hCD, 2'b11});
    end
    tick();
    checks++;
    if (a_fd !== 1'b1) begin errors++; $display("FAIL single_next_done got %0d exp 1", a_fd); end
  endtask

  task automatic test_mid_reset();
    a_w = 16'd4; a_h = 16'd2; a_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      a_tvalid = 1'b1;
      a_tdata  = 8'h50 + 8'(c);
      tick();
    end
    a_tvalid = 1'b0;
    checks++;
    if (a_fill !== 7'd3) begin errors++; $display("FAIL rst_pre_fill got %0d exp 3", a_fill); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({a_mv, a_md, a_mu, a_ml, a_fill} !== 18'd0) begin
      errors++; $display("FAIL rst_async got %0h exp 0", {a_mv, a_md, a_mu, a_ml, a_fill});
    end
    tick();
    rst = 1'b0;
    a_w = 16'd2; a_h = 16'd1; a_rdy = 1'b1;
    a_tvalid = 1'b1; a_tdata = 8'h60;
    tick();
    a_tdata = 8'h61;
    checks++;
    if ({a_mv, a_md, a_mu, a_ml} !== {1'b1, 8'h60, 2'b10}) begin
      errors++; $display("FAIL rst_sof got %0h exp %0h", {a_mv, a_md, a_mu, a_ml}, {1'b1, 8'h60, 2'b10});
    end
    tick();
    a_tvalid = 1'b0;
    checks++;
    if ({a_mv, a_md, a_mu, a_ml} !== {1'b1, 8'h61, 2'b01}) begin
      errors++; $display("FAIL rst_newdim got %0h exp %0h", {a_mv, a_md, a_mu, a_ml}, {1'b1, 8'h61, 2'b01});
    end
    tick();
    checks++;
    if (a_fd !== 1'b1) begin errors++; $display("FAIL rst_done got %0d exp 1", a_fd); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_full_pop();
    test_single_pixel();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
